// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch with credit-limited PC-tagged FIFO and redirect flush
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr_data,
  output logic [31:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [63:0]   mem_q [DEPTH];
  logic          grant, resp, push, pop;
  // Handshakes, outputs and next-state; a redirect overrides every other update
  always_comb begin
    redir_pc    = {redirect_pc[31:2], 2'b00};
    imem_req    = !reset && !redirect_valid && (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
    imem_addr   = fetch_pc_q;
    instr_valid = (count_q != '0) && !redirect_valid;
    instr_data  = (count_q != '0) ? mem_q[rptr_q][63:32] : 32'h0;
    instr_pc    = (count_q != '0) ? mem_q[rptr_q][31:0] : 32'h0;
    fifo_count  = count_q;
    grant       = imem_req && imem_gnt;
    resp        = imem_rvalid && (inflight_q != '0);
    push        = resp && (discard_q == '0) && !redirect_valid;
    pop         = instr_valid && instr_ready;
    inflight_d  = inflight_q + CW'(grant) - CW'(resp);
    discard_d   = redirect_valid ? inflight_d : discard_q - CW'(resp && (discard_q != '0));
    fetch_pc_d  = redirect_valid ? redir_pc : fetch_pc_q + (grant ? 32'd4 : 32'd0);
    resp_pc_d   = redirect_valid ? redir_pc : resp_pc_q + (push ? 32'd4 : 32'd0);
    count_d     = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    wptr_d      = redirect_valid ? '0 : wptr_q + PW'(push);
    rptr_d      = redirect_valid ? '0 : rptr_q + PW'(pop);
  end
  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end
  // FIFO storage of {data, pc}; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {imem_rdata, resp_pc_q};
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table vectors plus scoreboarded directed and random traffic for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, imem_gnt, imem_rvalid, instr_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr_data, instr_pc;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .fifo_count(fifo_count)
  );

  typedef struct packed {logic [31:0] addr; logic stale;} req_t;
  typedef struct {
    bit rst, rd; logic [31:0] rpc; bit g, rv, rdy;
    bit x_req; logic [31:0] x_addr; bit x_valid; logic [31:0] x_pc; int x_cnt;
  } vec_t;

  req_t        outq[$];
  logic [63:0] expq[$];
  logic [31:0] m_fetch;
  bit          m_init, e_req, e_valid;
  int          n_cmp, n_bad, dgrants;
  vec_t        tbl[8];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit rd, input logic [31:0] rpc, input bit g, input bit rv, input bit rdy);
    int st;
    reset = rst; redirect_valid = rd; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rv; instr_ready = rdy;
    imem_rdata = (outq.size() != 0) ? memf(outq[0].addr) : $urandom;
    #1;
    e_req   = !rst && !rd && (expq.size() + outq.size() < DEPTH);
    e_valid = (expq.size() != 0) && !rd;
    if (m_init) begin
      st = 0;
      foreach (outq[i]) if (outq[i].stale) st++;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("imem_addr", imem_addr, m_fetch);
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("fifo_count", 32'(fifo_count), 32'(expq.size()));
      chk("instr_pc", instr_pc, (expq.size() != 0) ? expq[0][63:32] : 32'h0);
      chk("instr_data", instr_data, (expq.size() != 0) ? expq[0][31:0] : 32'h0);
      chk("inflight", 32'(dut.inflight_q), 32'(outq.size()));
      chk("discard", 32'(dut.discard_q), 32'(st));
    end
  endtask

  task automatic advance();
    bit   resp;
    req_t r;
    if (imem_req && imem_gnt) dgrants++;
    if (reset) begin
      m_fetch = RPC; outq.delete(); expq.delete(); m_init = 1'b1;
    end else begin
      resp = imem_rvalid && (outq.size() != 0);
      r    = '0;
      if (resp) r = outq.pop_front();
      if (redirect_valid) begin
        expq.delete();
        foreach (outq[i]) outq[i].stale = 1'b1;
        m_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (e_valid && instr_ready) void'(expq.pop_front());
        if (resp && !r.stale) expq.push_back({r.addr, memf(r.addr)});
        if (e_req && imem_gnt) begin
          outq.push_back('{m_fetch, 1'b0});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle(input bit rst, input bit rd, input logic [31:0] rpc, input bit g, input bit rv, input bit rdy);
    drive(rst, rd, rpc, g, rv, rdy);
    advance();
  endtask

  initial begin
    int low;
    tbl[0] = '{0, 0, 32'h0,   1, 0, 1, 1, 32'h0,   0, 32'h0,   0};
    tbl[1] = '{0, 0, 32'h0,   1, 0, 1, 1, 32'h4,   0, 32'h0,   0};
    tbl[2] = '{0, 1, 32'h103, 1, 0, 1, 0, 32'h8,   0, 32'h0,   0};
    tbl[3] = '{0, 0, 32'h0,   0, 1, 1, 1, 32'h100, 0, 32'h0,   0};
    tbl[4] = '{0, 0, 32'h0,   1, 1, 1, 1, 32'h100, 0, 32'h0,   0};
    tbl[5] = '{0, 0, 32'h0,   0, 1, 1, 1, 32'h104, 0, 32'h0,   0};
    tbl[6] = '{0, 0, 32'h0,   0, 0, 1, 1, 32'h104, 1, 32'h100, 1};
    tbl[7] = '{0, 0, 32'h0,   0, 0, 1, 1, 32'h104, 0, 32'h0,   0};
    n_cmp = 0; n_bad = 0; dgrants = 0; m_init = 1'b0; m_fetch = RPC;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; imem_rdata = '0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // redirect with two requests in flight: late responses dropped, delivery restarts at 0x100
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].rd, tbl[k].rpc, tbl[k].g, tbl[k].rv, tbl[k].rdy);
      chk($sformatf("t%0d_req", k), 32'(imem_req), 32'(tbl[k].x_req));
      chk($sformatf("t%0d_addr", k), imem_addr, tbl[k].x_addr);
      chk($sformatf("t%0d_valid", k), 32'(instr_valid), 32'(tbl[k].x_valid));
      chk($sformatf("t%0d_pc", k), instr_pc, tbl[k].x_pc);
      chk($sformatf("t%0d_cnt", k), 32'(fifo_count), 32'(tbl[k].x_cnt));
      advance();
    end
    // streaming: response one cycle after each grant, decode always ready
    cycle(1, 0, 0, 0, 0, 0);
    low = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 0, 1, outq.size() != 0, 1);
      if (i > 0 && !imem_req) low++;
      advance();
    end
    chk("p1_req_low_cycles", 32'(low), 32'd0);
    // decode stalled: credits stop fetch at DEPTH
    cycle(1, 0, 0, 0, 0, 0);
    dgrants = 0;
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, outq.size() != 0, 0);
    chk("p2_grants", 32'(dgrants), 32'd4);
    drive(0, 0, 0, 1, 0, 1);
    chk("p2_full_count", 32'(fifo_count), 32'd4);
    chk("p2_full_req", 32'(imem_req), 32'd0);
    advance();
    drive(0, 0, 0, 1, 0, 0);
    chk("p2_req_after_pop", 32'(imem_req), 32'd1);
    advance();
    chk("p2_one_more_grant", 32'(dgrants), 32'd5);
    // redirect with response and ready in the same cycle, FIFO non-empty
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 0);
    drive(0, 1, 32'h200, 0, 1, 1);
    chk("p4_no_pop_valid", 32'(instr_valid), 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("p4_count", 32'(fifo_count), 32'd0);
    chk("p4_discard", 32'(dut.discard_q), 32'd1);
    advance();
    cycle(0, 0, 0, 0, 1, 0);
    // wrap of the fetch address at the top of memory
    cycle(0, 1, 32'hFFFF_FFFE, 0, 0, 1);
    drive(0, 0, 0, 1, outq.size() != 0, 1);
    chk("p5_addr_top", imem_addr, 32'hFFFF_FFFC);
    advance();
    drive(0, 0, 0, 1, outq.size() != 0, 1);
    chk("p5_addr_wrap", imem_addr, 32'h0);
    advance();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, outq.size() != 0, 1);
    // reset with three in flight; stale responses afterwards are ignored
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    chk("p6_inflight_before", 32'(dut.inflight_q), 32'd3);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("p6_first_addr", imem_addr, RPC);
    chk("p6_valid_idle", 32'(instr_valid), 32'd0);
    advance();
    drive(0, 0, 0, 0, 1, 0);
    chk("p6_valid_wait", 32'(instr_valid), 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 1);
    chk("p6_valid_now", 32'(instr_valid), 32'd1);
    chk("p6_pc", instr_pc, RPC);
    advance();
    // random traffic with spurious responses, redirects and occasional reset
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
